hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
- Sequences the ID-stage stall and bubble controls for the 5-stage pipeline.
- Tracks in-flight register writes in a destination scoreboard covering EX/MEM/WB.
- Drives PC/IF-ID hold, bubble insertion into ID/EX, IF/ID flush on taken branch/jump, and halt drain.
- Sits between the ID decoder and the control-zeroing stage ahead of ID/EX.

Parameters:
- REG_W, 5, register index width.
- DEPTH, 3, scoreboard entries (EX, MEM, WB); entry 0 = EX.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  REG_W  source register 1.
- id_rt  in  REG_W  source register 2.
- id_use_rs  in  1  instruction reads rs.
- id_use_rt  in  1  instruction reads rt.
- id_reg_write  in  1  instruction writes a register.
- id_dst  in  REG_W  destination (post-RegDst mux).
- id_mem_read  in  1  instruction is a load.
- id_halt  in  1  instruction is HALT.
- ex_redirect  in  1  taken branch/jump resolved in EX this cycle.
- pc_hold  out  1  freeze PC.
- ifid_hold  out  1  freeze IF/ID.
- bubble  out  1  zero controls entering ID/EX.
- ifid_flush  out  1  clear IF/ID to NOP.
- halted  out  1  pipeline drained after HALT; sticky.
- stall_count  out  CNT_W  cycles with bubble=1 due to data hazards.

Behaviour:
- Reset (async, rst_n=0):
  - All scoreboard entries invalid; state RUN; stall_count=0.
  - Outputs pc_hold=0, ifid_hold=0, bubble=0, ifid_flush=0, halted=0.
- Scoreboard: each entry holds {valid, dst, load}. Shifts every cycle; entry DEPTH-1 is discarded.
  - New entry 0 = {id_valid & id_reg_write & ~bubble & ~ifid_flush & id_dst!=0, id_dst, id_mem_read}.
- Hazard (combinational from scoreboard state + ID inputs):
  - Condition: id_valid, (use_rs & rs matches a valid dst) or (use_rt & rt matches a valid dst).
  - Register 0 never hazards.
  - WB entry counts as a hazard: the register file is write-then-read safe only from the next cycle.
- States:
  - RUN:
    - ex_redirect → ifid_flush=1, bubble=1, no hold; takes priority over the hazard check in the same cycle.
    - Else hazard → pc_hold=ifid_hold=bubble=1; stall_count+=1, saturating at all-ones.
    - Else id_valid & id_halt & no hazard → go to DRAIN; the HALT itself issues.
  - DRAIN:
    - pc_hold=ifid_hold=1, bubble=1.
    - When all scoreboard entries are invalid → HALTED.
    - ex_redirect in DRAIN: ignored (HALT is already past ID, younger instructions only).
  - HALTED: halted=1, pc_hold=ifid_hold=bubble=1; exits only via reset.
- Timing:
  - Hold, bubble and flush outputs are combinational (same-cycle) against registered state.
  - halted is registered, rising the cycle after the scoreboard empties.
- Stall length: a dependent instruction stalls until its producer leaves WB, at most DEPTH cycles; it issues the cycle the match disappears.
- Simultaneous hazards on rs and rt: one stall sequence, lasting the longer of the two.
- Reset mid-stall or mid-drain: everything returns to reset values immediately.

Optional Feature:
- FORWARD_EN defined:
  - Only load-use hazards stall: match against entry 0 with load=1 → exactly 1 bubble.
  - All other matches are forwarded and cause no stall.
- Undefined: full scoreboard stalling as above.
- Port list is identical in both cases.

Decomposition:
- Shared package pipe_pkg holds:
  - sb_entry_t {valid, dst, load}.
  - Constants REG_W=5, SB_DEPTH=3, REG_ZERO=0.
  - State enum {RUN, DRAIN, HALTED}.
- One natural sub-module: dst_scoreboard, the shift register plus match logic.
  - Inputs: push entry, rs/rt with use flags.
  - Outputs: hit_rs, hit_rt, empty.

Test Plan:
- Independent stream: add r1; add r2,r3,r4 with rs/rt ≠ r1 → no stalls, stall_count=0.
- RAW on ALU result, no FORWARD_EN: add r5; next reads rs=r5 → bubble=1 and pc_hold=1 for 3 cycles, issue on the 4th, stall_count=3.
- Same with FORWARD_EN: add r5 then read r5 → 0 stalls. lw r6 then read rt=r6 → exactly 1 bubble, stall_count=1.
- r0 write: add r0 then read r0 → no stall. Scoreboard entry pushed invalid.
- Redirect during hazard: hazard active and ex_redirect=1 same cycle → ifid_flush=1, bubble=1, pc_hold=0, stall_count unchanged.
- Halt drain: lw r7, HALT → pc_hold stays 1; halted rises once the lw leaves WB (3 cycles after HALT issues). Remains 1 until rst_n=0, which clears halted, stall_count and all holds asynchronously.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the ID-stage hazard/stall control slice.
// FORWARD_EN (optional macro) restricts stalls to load-use hazards in dst_scoreboard.
package pipe_pkg;

    localparam int REG_W    = 5;
    localparam int SB_DEPTH = 3;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] dst;
        logic             load;
    } sb_entry_t;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    // A source register matches an in-flight write; r0 is hardwired and never matches.
    function automatic logic reg_match(input sb_entry_t e, input logic [REG_W-1:0] r);
        return e.valid && (e.dst == r) && (r != REG_ZERO);
    endfunction

endpackage

// File: rtl/dst_scoreboard.sv
// Destination scoreboard for EX/MEM/WB (entry 0 = EX) with source-match logic.
// With FORWARD_EN defined only a load sitting in EX produces a hit.
module dst_scoreboard
    import pipe_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  sb_entry_t        push,
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    input  logic             use_rs,
    input  logic             use_rt,
    output logic             hit_rs,
    output logic             hit_rt,
    output logic             empty
);

    sb_entry_t sb_r [DEPTH];

    // Shift register: one stage per cycle, the WB entry falls off the end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                sb_r[i] <= '0;
            end
        end else begin
            sb_r[0] <= push;
            for (int i = 1; i < DEPTH; i++) begin
                sb_r[i] <= sb_r[i-1];
            end
        end
    end

    // Source matching and occupancy.
    always_comb begin
        hit_rs = 1'b0;
        hit_rt = 1'b0;
        empty  = 1'b1;
`ifdef FORWARD_EN
        hit_rs = use_rs & sb_r[0].load & reg_match(sb_r[0], rs);
        hit_rt = use_rt & sb_r[0].load & reg_match(sb_r[0], rt);
`else
        for (int i = 0; i < DEPTH; i++) begin
            hit_rs = hit_rs | (use_rs & reg_match(sb_r[i], rs));
            hit_rt = hit_rt | (use_rt & reg_match(sb_r[i], rt));
        end
`endif
        for (int i = 0; i < DEPTH; i++) begin
            empty = empty & ~sb_r[i].valid;
        end
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ID-stage stall/bubble/flush sequencer with HALT drain; optional macro FORWARD_EN
// limits data-hazard stalls to load-use (see dst_scoreboard).
module hazard_stall_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int DEPTH = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_reg_write,
    input  logic [REG_W-1:0] id_dst,
    input  logic             id_mem_read,
    input  logic             id_halt,
    input  logic             ex_redirect,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             bubble,
    output logic             ifid_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count
);

    state_t           state_r;
    state_t           state_next_s;
    logic [CNT_W-1:0] count_r;
    logic             halted_r;
    logic             cnt_inc_s;
    logic             hit_rs_s;
    logic             hit_rt_s;
    logic             empty_s;
    logic             hazard_s;
    sb_entry_t        push_s;

    assign hazard_s    = id_valid & (hit_rs_s | hit_rt_s);
    assign halted      = halted_r;
    assign stall_count = count_r;

    dst_scoreboard #(
        .DEPTH (DEPTH)
    ) u_sb (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (push_s),
        .rs     (id_rs),
        .rt     (id_rt),
        .use_rs (id_use_rs),
        .use_rt (id_use_rt),
        .hit_rs (hit_rs_s),
        .hit_rt (hit_rt_s),
        .empty  (empty_s)
    );

    // Next state and same-cycle hold/bubble/flush; redirect outranks the hazard check.
    always_comb begin
        state_next_s = state_r;
        pc_hold      = 1'b0;
        ifid_hold    = 1'b0;
        bubble       = 1'b0;
        ifid_flush   = 1'b0;
        cnt_inc_s    = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (ex_redirect) begin
                    ifid_flush = 1'b1;
                    bubble     = 1'b1;
                end else if (hazard_s) begin
                    pc_hold   = 1'b1;
                    ifid_hold = 1'b1;
                    bubble    = 1'b1;
                    cnt_inc_s = 1'b1;
                end else if (id_valid && id_halt) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                pc_hold   = 1'b1;
                ifid_hold = 1'b1;
                bubble    = 1'b1;
                if (empty_s) begin
                    state_next_s = ST_HALTED;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            ST_HALTED: begin
                pc_hold   = 1'b1;
                ifid_hold = 1'b1;
                bubble    = 1'b1;
            end
            default: begin
                state_next_s = ST_RUN;
                pc_hold      = 1'b1;
                ifid_hold    = 1'b1;
                bubble       = 1'b1;
            end
        endcase
    end

    // Only instructions that actually leave ID (no bubble, no flush) occupy the scoreboard.
    always_comb begin
        push_s.valid = id_valid & id_reg_write & ~bubble & ~ifid_flush & (id_dst != REG_ZERO);
        push_s.dst   = id_dst;
        push_s.load  = id_mem_read;
    end

    // State, sticky halted flag and saturating data-hazard stall counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_RUN;
            halted_r <= 1'b0;
            count_r  <= {CNT_W{1'b0}};
        end else begin
            state_r  <= state_next_s;
            halted_r <= (state_next_s == ST_HALTED);
            if (cnt_inc_s && (count_r != {CNT_W{1'b1}})) begin
                count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                count_r <= count_r;
            end
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: a per-register "last issue cycle" model checked
// every cycle, plus literal expectations at key points.
module tb_hazard_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rs = 5'd0;
    logic [4:0]  id_rt = 5'd0;
    logic        id_use_rs = 1'b0;
    logic        id_use_rt = 1'b0;
    logic        id_reg_write = 1'b0;
    logic [4:0]  id_dst = 5'd0;
    logic        id_mem_read = 1'b0;
    logic        id_halt = 1'b0;
    logic        ex_redirect = 1'b0;
    logic        pc_hold, ifid_hold, bubble, ifid_flush, halted;
    logic [15:0] stall_count;

    int total = 0;
    int bad = 0;

    hazard_stall_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_use_rs    (id_use_rs),
        .id_use_rt    (id_use_rt),
        .id_reg_write (id_reg_write),
        .id_dst       (id_dst),
        .id_mem_read  (id_mem_read),
        .id_halt      (id_halt),
        .ex_redirect  (ex_redirect),
        .pc_hold      (pc_hold),
        .ifid_hold    (ifid_hold),
        .bubble       (bubble),
        .ifid_flush   (ifid_flush),
        .halted       (halted),
        .stall_count  (stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: cycle of the latest issued write per register; mode 0=run 1=drain 2=halted.
    int cyc;
    int wr_cyc [32];
    bit wr_ld [32];
    int mode;
    int scnt;
    bit m_issued;

    function automatic bit recent(input int r);
        int d;
        d = cyc - wr_cyc[r];
`ifdef FORWARD_EN
        return (r != 0) && (d == 1) && wr_ld[r];
`else
        return (r != 0) && (d >= 1) && (d <= 3);
`endif
    endfunction

    function automatic bit in_flight_none();
        bit e;
        e = 1'b1;
        for (int r = 1; r < 32; r++) begin
            if ((cyc - wr_cyc[r] >= 1) && (cyc - wr_cyc[r] <= 3)) e = 1'b0;
        end
        return e;
    endfunction

    task automatic model_reset();
        cyc = 0;
        mode = 0;
        scnt = 0;
        for (int r = 0; r < 32; r++) begin
            wr_cyc[r] = -100;
            wr_ld[r] = 1'b0;
        end
    endtask

    bit haz, e_hold, e_bub, e_fl;
    int nmode;

    // Compare process: outputs checked against the model on every falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_pc_hold", {31'd0, pc_hold}, 32'd0);
            chk("rst_bubble", {31'd0, bubble}, 32'd0);
            chk("rst_flush", {31'd0, ifid_flush}, 32'd0);
            chk("rst_halted", {31'd0, halted}, 32'd0);
            chk("rst_count", {16'd0, stall_count}, 32'd0);
            model_reset();
            m_issued = 1'b0;
        end else begin
            haz = id_valid && ((id_use_rs && recent(int'(id_rs))) || (id_use_rt && recent(int'(id_rt))));
            e_hold = 1'b0; e_bub = 1'b0; e_fl = 1'b0; nmode = mode; m_issued = 1'b0;
            if (mode == 0) begin
                if (ex_redirect) begin
                    e_fl = 1'b1; e_bub = 1'b1;
                end else if (haz) begin
                    e_hold = 1'b1; e_bub = 1'b1;
                end else begin
                    m_issued = id_valid;
                    if (id_valid && id_halt) nmode = 1;
                end
            end else begin
                e_hold = 1'b1; e_bub = 1'b1;
                if (mode == 1 && in_flight_none()) nmode = 2;
            end
            chk("pc_hold", {31'd0, pc_hold}, {31'd0, e_hold});
            chk("ifid_hold", {31'd0, ifid_hold}, {31'd0, e_hold});
            chk("bubble", {31'd0, bubble}, {31'd0, e_bub});
            chk("ifid_flush", {31'd0, ifid_flush}, {31'd0, e_fl});
            chk("halted", {31'd0, halted}, (mode == 2) ? 32'd1 : 32'd0);
            chk("stall_count", {16'd0, stall_count}, scnt);
            if (mode == 0 && !ex_redirect && haz && scnt < 65535) scnt++;
            if (m_issued && id_reg_write && id_dst != 5'd0) begin
                wr_cyc[id_dst] = cyc;
                wr_ld[id_dst] = id_mem_read;
            end
            mode = nmode;
            cyc++;
        end
    end

    task automatic set_in(input bit v, input int rs, input bit urs, input int rt, input bit urt,
                          input bit wr, input int dst, input bit ld, input bit hlt, input bit redir);
        id_valid = v; id_rs = rs[4:0]; id_use_rs = urs; id_rt = rt[4:0]; id_use_rt = urt;
        id_reg_write = wr; id_dst = dst[4:0]; id_mem_read = ld; id_halt = hlt; ex_redirect = redir;
    endtask

    task automatic next_cycle();
        @(negedge clk); #1;
        @(posedge clk); #1;
    endtask

    // Hold one instruction in ID until the model says it issued (bounded).
    task automatic issue(input string name, input int rs, input bit urs, input int rt, input bit urt,
                         input bit wr, input int dst, input bit ld, input bit hlt);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 8 && !done; k++) begin
            set_in(1'b1, rs, urs, rt, urt, wr, dst, ld, hlt, 1'b0);
            @(negedge clk); #1;
            done = m_issued;
            @(posedge clk); #1;
        end
        if (!done) chk({"issue_timeout_", name}, 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            set_in(1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
            next_cycle();
        end
    endtask

    initial begin
        model_reset();
        #1;
        chk("lit_reset_pc_hold", {31'd0, pc_hold}, 32'd0);
        chk("lit_reset_halted", {31'd0, halted}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // independent stream
        issue("add_r1", 2, 1'b1, 3, 1'b1, 1'b1, 1, 1'b0, 1'b0);
        issue("add_r2", 3, 1'b1, 4, 1'b1, 1'b1, 2, 1'b0, 1'b0);
        issue("add_r3", 4, 1'b1, 5, 1'b1, 1'b1, 3, 1'b0, 1'b0);
        chk("lit_indep_count", {16'd0, stall_count}, 32'd0);
        idle(4);

        // RAW on ALU result
        issue("add_r5", 1, 1'b1, 2, 1'b1, 1'b1, 5, 1'b0, 1'b0);
        issue("use_r5", 5, 1'b1, 6, 1'b1, 1'b1, 10, 1'b0, 1'b0);
`ifdef FORWARD_EN
        chk("lit_raw_count", {16'd0, stall_count}, 32'd0);
`else
        chk("lit_raw_count", {16'd0, stall_count}, 32'd3);
`endif
        idle(4);

        // load-use on rt, with both operands hitting the same load
        issue("lw_r6", 1, 1'b1, 0, 1'b0, 1'b1, 6, 1'b1, 1'b0);
        issue("use_r6", 6, 1'b1, 6, 1'b1, 1'b1, 11, 1'b0, 1'b0);
`ifdef FORWARD_EN
        chk("lit_load_count", {16'd0, stall_count}, 32'd1);
`else
        chk("lit_load_count", {16'd0, stall_count}, 32'd6);
`endif
        idle(4);

        // r0 writes never create a hazard
        issue("add_r0", 1, 1'b1, 2, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        issue("use_r0", 0, 1'b1, 0, 1'b1, 1'b1, 12, 1'b0, 1'b0);
        idle(4);

        // redirect outranks an active hazard
        issue("add_r8", 1, 1'b1, 2, 1'b1, 1'b1, 8, 1'b0, 1'b0);
        set_in(1'b1, 8, 1'b1, 0, 1'b0, 1'b1, 13, 1'b0, 1'b0, 1'b1);
        @(negedge clk); #1;
        chk("lit_redir_flush", {31'd0, ifid_flush}, 32'd1);
        chk("lit_redir_pc_hold", {31'd0, pc_hold}, 32'd0);
        @(posedge clk); #1;
        idle(4);

        // reset in the middle of a stall
        issue("add_r9", 1, 1'b1, 2, 1'b1, 1'b1, 9, 1'b0, 1'b0);
        set_in(1'b1, 9, 1'b1, 0, 1'b0, 1'b1, 14, 1'b0, 1'b0, 1'b0);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("lit_midstall_rst_hold", {31'd0, pc_hold}, 32'd0);
        chk("lit_midstall_rst_count", {16'd0, stall_count}, 32'd0);
        @(posedge clk); #1;
        idle(1);
        rst_n = 1'b1;
        idle(1);

        // halt drain behind a load
        issue("lw_r7", 1, 1'b1, 0, 1'b0, 1'b1, 7, 1'b1, 1'b0);
        issue("halt", 0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        set_in(1'b1, 7, 1'b1, 0, 1'b0, 1'b1, 15, 1'b0, 1'b0, 1'b1);
        repeat (3) begin
            @(negedge clk); #1;
        end
        chk("lit_drain_hold", {31'd0, pc_hold}, 32'd1);
        chk("lit_drain_not_halted", {31'd0, halted}, 32'd0);
        @(negedge clk); #1;
        chk("lit_halted", {31'd0, halted}, 32'd1);
        @(posedge clk); #1;
        idle(3);
        chk("lit_halted_sticky", {31'd0, halted}, 32'd1);

        // asynchronous reset out of HALTED
        rst_n = 1'b0;
        #1;
        chk("lit_rst_halted", {31'd0, halted}, 32'd0);
        chk("lit_rst_pc_hold", {31'd0, pc_hold}, 32'd0);
        chk("lit_rst_count", {16'd0, stall_count}, 32'd0);
        @(posedge clk); #1;
        idle(1);
        rst_n = 1'b1;
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
